// File: rtl/ram_write_scheduler_pkg.sv
// Shared types for the RAM write scheduler.
//   ram_sched_state_t : scheduler FSM state (CLEAR sweep / RUN pass-through)
//   ram_sel_t         : source selected onto RAM port A
//   CPU_ADDR_WIDTH    : width of the CPU store address bus
package ram_sched_pkg;

  typedef enum logic {CLEAR, RUN} ram_sched_state_t;

  typedef enum logic [1:0] {SEL_CLEAR, SEL_CPU, SEL_HOST} ram_sel_t;

  localparam int CPU_ADDR_WIDTH = 15;

endpackage

// File: rtl/ram_write_scheduler_if.sv
// Host/debug write channel (valid/ready handshake).
//   host_valid : write request, held with addr/data until accepted
//   host_addr  : RAM word address
//   host_data  : RAM word data
//   host_ready : write accepted in a cycle where host_valid is also 1
interface ram_write_scheduler_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  host_valid;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic                  host_ready;

  modport master (
    output host_valid, host_addr, host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_addr, host_data,
    output host_ready
  );
endinterface

// File: rtl/ram_write_mux.sv
// Combinational 3-way source select for RAM port A.
//   sel             : source select (clear sweep, CPU, host)
//   host_wr         : host write actually granted this cycle
//   clr_addr/data   : sweep address and fill word
//   cpu_addr/data   : CPU store address (already truncated) and data
//   host_addr/data  : host write address and data
//   wren/addr/data  : RAM port A drive
module ram_write_mux
  import ram_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  ram_sel_t              sel,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [DATA_WIDTH-1:0] clr_data,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    wren = host_wr;
    addr = host_addr;
    data = host_data;
    case (sel)
      SEL_CLEAR: begin
        wren = 1'b1;
        addr = clr_addr;
        data = clr_data;
      end
      SEL_CPU: begin
        wren = 1'b1;
        addr = cpu_addr;
        data = cpu_data;
      end
      default: begin
        // Host path: address/data always presented, strobe only on grant.
        wren = host_wr;
        addr = host_addr;
        data = host_data;
      end
    endcase
  end

endmodule

// File: rtl/ram_write_scheduler.sv
// Sequencer/arbiter for the shared write port A of the data/VGA RAMs.
// Sweeps every word with FILL_VALUE after reset or clear_req while holding
// the CPU in reset, then passes CPU stores through with zero latency and
// grants idle slots to the host channel.
//   clk, reset          : CPU clock, async active-high reset
//   clear_req           : single-cycle request to re-run the sweep (RUN only)
//   cpu_write_m/addr/out: CPU store strobe, address (low bits used), data
//   host                : host write channel (slave side)
//   ram_wren/addr/data  : RAM port A drive (combinational)
//   cpu_hold            : registered, keeps the CPU in reset while 1
//   clear_done          : registered one-cycle pulse on the first RUN cycle
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | writing FILL_VALUE to address clr_cnt, CPU held, host stalled
// RUN   | CPU stores pass through; host gets slots the CPU leaves idle
module ram_write_scheduler
  import ram_sched_pkg::*;
#(
  parameter int                    DATA_WIDTH         = 16,
  parameter int                    RAM_REGISTER_COUNT = 2**10,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE         = {DATA_WIDTH{1'b0}},
  localparam int                   ADDR_WIDTH         = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_req,
  input  logic                      cpu_write_m,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_write_data_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_out_m,
  ram_write_scheduler_if.slave      host,
  output logic                      ram_wren,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_data,
  output logic                      cpu_hold,
  output logic                      clear_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);

  ram_sched_state_t      state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  ram_sel_t              sel;
  logic                  host_ready_c;
  logic                  host_wr;

  // CPU addresses beyond the RAM depth simply wrap; upper bits are dropped.
  logic unused_cpu_addr_bits;
  assign unused_cpu_addr_bits = ^cpu_write_data_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      cpu_hold   <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state      <= RUN;
            clr_cnt    <= '0;
            cpu_hold   <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          // Any store granted this cycle still lands; the sweep starts next cycle.
          if (clear_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            cpu_hold <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  always_comb begin
    sel          = SEL_HOST;
    host_ready_c = 1'b0;
    host_wr      = 1'b0;
    if (state == CLEAR) begin
      sel = SEL_CLEAR;
    end else if (cpu_write_m) begin
      sel = SEL_CPU;
    end else begin
      host_ready_c = 1'b1;
      host_wr      = host.host_valid;
    end
  end

  assign host.host_ready = host_ready_c;

  ram_write_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .sel       (sel),
    .host_wr   (host_wr),
    .clr_addr  (clr_cnt),
    .clr_data  (FILL_VALUE),
    .cpu_addr  (cpu_write_data_addr[ADDR_WIDTH-1:0]),
    .cpu_data  (cpu_out_m),
    .host_addr (host.host_addr),
    .host_data (host.host_data),
    .wren      (ram_wren),
    .addr      (ram_addr),
    .data      (ram_data)
  );

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Scoreboard bench for ram_write_scheduler (depth 16, fill A5A5).
module tb_ram_write_scheduler;
  import ram_sched_pkg::*;

  localparam int              DW    = 16;
  localparam int              DEPTH = 16;
  localparam int              AW    = 4;
  localparam logic [DW-1:0]   FILL  = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic          cpu_write_m;
  logic [14:0]   cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          cpu_hold;
  logic          clear_done;

  ram_write_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_if ();

  ram_write_scheduler #(
    .DATA_WIDTH         (DW),
    .RAM_REGISTER_COUNT (DEPTH),
    .FILL_VALUE         (FILL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clear_req           (clear_req),
    .cpu_write_m         (cpu_write_m),
    .cpu_write_data_addr (cpu_addr),
    .cpu_out_m           (cpu_data),
    .host                (host_if),
    .ram_wren            (ram_wren),
    .ram_addr            (ram_addr),
    .ram_data            (ram_data),
    .cpu_hold            (cpu_hold),
    .clear_done          (clear_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hr;
    logic          hold;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic wren, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic hr, input logic hold, input logic done);
    exp_t e;
    e.wren = wren; e.addr = a; e.data = d; e.hr = hr; e.hold = hold; e.done = done;
    return e;
  endfunction

  // One expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ram_wren", 32'(ram_wren), 32'(e.wren));
      if (e.wren) begin
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        check("ram_data", 32'(ram_data), 32'(e.data));
      end
      check("host_ready", 32'(host_if.host_ready), 32'(e.hr));
      check("cpu_hold", 32'(cpu_hold), 32'(e.hold));
      check("clear_done", 32'(clear_done), 32'(e.done));
    end
  end

  task automatic step(input logic wr, input logic [14:0] a, input logic [DW-1:0] d,
                      input logic hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      input logic cr, input exp_t e);
    cpu_write_m        = wr;
    cpu_addr           = a;
    cpu_data           = d;
    host_if.host_valid = hv;
    host_if.host_addr  = ha;
    host_if.host_data  = hd;
    clear_req          = cr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input exp_t e);
    step(1'b0, 15'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, e);
  endtask

  // Sweep cycles n_from..n_to; noisy drives CPU/host/clear_req that must be ignored.
  task automatic sweep_part(input int n_from, input int n_to, input logic noisy);
    for (int i = n_from; i <= n_to; i++) begin
      if (noisy)
        step(1'b1, 15'($urandom), 16'($urandom), 1'b1, 4'hC, 16'hDEAD,
             (i == 3 || i == 10), mk(1'b1, AW'(i), FILL, 1'b0, 1'b1, 1'b0));
      else
        idle(mk(1'b1, AW'(i), FILL, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic sweep_full(input logic noisy);
    sweep_part(0, DEPTH - 1, noisy);
    idle(mk(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b1));
  endtask

  initial begin
    reset = 1'b1;
    clear_req = 1'b0;
    cpu_write_m = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    host_if.host_valid = 1'b0;
    host_if.host_addr = '0;
    host_if.host_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;

    sweep_full(1'b0);

    // CPU store, address wraps modulo depth.
    step(1'b1, 15'h0403, 16'h1234, 1'b0, 4'h0, 16'h0, 1'b0,
         mk(1'b1, 4'h3, 16'h1234, 1'b0, 1'b0, 1'b0));

    // Host stalled three cycles by CPU stores, then granted.
    step(1'b1, 15'h0001, 16'h1111, 1'b1, 4'h7, 16'hBEEF, 1'b0, mk(1'b1, 4'h1, 16'h1111, 1'b0, 1'b0, 1'b0));
    step(1'b1, 15'h0022, 16'h2222, 1'b1, 4'h7, 16'hBEEF, 1'b0, mk(1'b1, 4'h2, 16'h2222, 1'b0, 1'b0, 1'b0));
    step(1'b1, 15'h7FFB, 16'h3333, 1'b1, 4'h7, 16'hBEEF, 1'b0, mk(1'b1, 4'hB, 16'h3333, 1'b0, 1'b0, 1'b0));
    step(1'b0, 15'h0000, 16'h0000, 1'b1, 4'h7, 16'hBEEF, 1'b0, mk(1'b1, 4'h7, 16'hBEEF, 1'b1, 1'b0, 1'b0));

    // Host with idle CPU: same-cycle grant; then nothing active.
    step(1'b0, 15'h0000, 16'h0000, 1'b1, 4'h9, 16'h0C0C, 1'b0, mk(1'b1, 4'h9, 16'h0C0C, 1'b1, 1'b0, 1'b0));
    idle(mk(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0));

    // clear_req with a coincident CPU store, then a sweep ignoring everything.
    step(1'b1, 15'h0002, 16'h0055, 1'b0, 4'h0, 16'h0, 1'b1, mk(1'b1, 4'h2, 16'h0055, 1'b0, 1'b0, 1'b0));
    sweep_full(1'b1);

    // clear_req with a host write, then reset at sweep address 9.
    step(1'b0, 15'h0000, 16'h0000, 1'b1, 4'hE, 16'h7777, 1'b1, mk(1'b1, 4'hE, 16'h7777, 1'b1, 1'b0, 1'b0));
    sweep_part(0, 8, 1'b0);
    check("pre_rst_addr", 32'(ram_addr), 32'd9);
    reset = 1'b1;
    #1;
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_data", 32'(ram_data), 32'(FILL));
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(clear_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sweep_full(1'b0);
    step(1'b1, 15'h0010, 16'h4321, 1'b0, 4'h0, 16'h0, 1'b0, mk(1'b1, 4'h0, 16'h4321, 1'b0, 1'b0, 1'b0));
    idle(mk(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 1'b0));

    @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
